// File: rtl/pwm_io_bank.sv
// Memory-mapped PWM bank: shared prescaler and period counter, one duty compare per channel.
// Define PWM_IO_BANK_SHADOW_EN to latch duty values only at period wrap (glitch-free updates).
module pwm_io_bank #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned PRE_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_mem,
  input  logic [31:0]       write_address,
  input  logic [31:0]       write_data,
  input  logic [31:0]       read_address,
  output logic [31:0]       read_data,
  output logic              read_hit,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  localparam logic [31:0] LastOff = 32'(15 + 4 * NUM_CH);

  logic             en_q, inv_q;
  logic [CNT_W-1:0] period_q;
  logic [PRE_W-1:0] prescale_q;
  logic [CNT_W-1:0] duty_q   [NUM_CH];
  logic [CNT_W-1:0] duty_act [NUM_CH];
  logic [PRE_W-1:0] pre_q;
  logic [CNT_W-1:0] cnt_q;
  logic [NUM_CH-1:0] pwm_q;
  logic             period_tick_q;
  logic [31:0]      read_data_q;
  logic             read_hit_q;

  logic [31:0] wr_off, rd_off;
  logic        wr_hit, rd_in_win, rd_aligned;
  logic [4:0]  wr_word, rd_word;
  logic        tick, wrap;
  logic [NUM_CH-1:0] raw;
  logic [31:0] rd_val;
  logic        unused_wdata;

  // Only word-aligned offsets select a register; other in-window bytes read as zero.
  assign wr_off     = write_address - BASE_ADDR;
  assign rd_off     = read_address - BASE_ADDR;
  assign wr_hit     = write_mem && (write_address >= BASE_ADDR) && (wr_off <= LastOff) &&
                      (wr_off[1:0] == 2'b00);
  assign rd_in_win  = (read_address >= BASE_ADDR) && (rd_off <= LastOff);
  assign rd_aligned = rd_in_win && (rd_off[1:0] == 2'b00);
  assign wr_word    = wr_off[6:2];
  assign rd_word    = rd_off[6:2];

  assign unused_wdata = ^write_data;

  always_comb begin
    tick = en_q && (pre_q >= prescale_q);
    wrap = tick && (cnt_q >= period_q);
  end

`ifdef PWM_IO_BANK_SHADOW_EN
  logic [CNT_W-1:0] shadow_q [NUM_CH];

  // On a wrap the shadow takes the pre-write DUTY value, even if DUTY is written that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else if (!en_q || wrap) begin
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= duty_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) duty_act[i] = shadow_q[i];
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) duty_act[i] = duty_q[i];
  end
`endif

  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) raw[i] = en_q && (cnt_q < duty_act[i]);
  end

  always_comb begin
    rd_val = '0;
    if (rd_aligned) begin
      case (rd_word)
        5'd0: rd_val[1:0] = {inv_q, en_q};
        5'd1: rd_val[CNT_W-1:0] = period_q;
        5'd2: rd_val[PRE_W-1:0] = prescale_q;
        5'd3: rd_val[CNT_W-1:0] = cnt_q;
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (rd_word == 5'(4 + i)) rd_val[CNT_W-1:0] = duty_q[i];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q       <= 1'b0;
      inv_q      <= 1'b0;
      period_q   <= '1;
      prescale_q <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
    end else if (wr_hit) begin
      case (wr_word)
        5'd0: begin
          en_q  <= write_data[0];
          inv_q <= write_data[1];
        end
        5'd1: period_q   <= write_data[CNT_W-1:0];
        5'd2: prescale_q <= write_data[PRE_W-1:0];
        5'd3: ;
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (wr_word == 5'(4 + i)) duty_q[i] <= write_data[CNT_W-1:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q         <= '0;
      cnt_q         <= '0;
      pwm_q         <= '0;
      period_tick_q <= 1'b0;
      read_data_q   <= '0;
      read_hit_q    <= 1'b0;
    end else begin
      if (!en_q || tick) pre_q <= '0;
      else               pre_q <= pre_q + 1'b1;

      if (!en_q || wrap) cnt_q <= '0;
      else if (tick)     cnt_q <= cnt_q + 1'b1;

      period_tick_q <= wrap;
      pwm_q         <= raw ^ {NUM_CH{inv_q}};
      read_data_q   <= rd_val;
      read_hit_q    <= rd_in_win;
    end
  end

  assign read_data   = read_data_q;
  assign read_hit    = read_hit_q;
  assign pwm_out     = pwm_q;
  assign period_tick = period_tick_q;

endmodule

// File: doc/pwm_io_bank.md
# pwm_io_bank

Memory-mapped, parametrised PWM output bank for the multicycle RISC-V SoC. It replaces fixed single-bit LED/RGB outputs with NUM_CH independent PWM channels. The channels share one prescaler and one period counter, and each channel has its own duty register. It sits on the same single-port data bus as the memory subsystem and decodes its own address window.

## Interface
Parameters:
- NUM_CH, 4: number of PWM channels (1..16).
- CNT_W, 8: width of period, duty and counter registers (2..16).
- PRE_W, 16: prescaler register width.
- BASE_ADDR, 32'hFFFF_FF00: word-aligned window base.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- write_mem  in  1  bus write strobe.
- write_address  in  32  bus write address.
- write_data  in  32  bus write data (full word; funct3 ignored).
- read_address  in  32  bus read address.
- read_data  out  32  registered read data.
- read_hit  out  1  registered; 1 when the previous-cycle read_address fell in the window.
- pwm_out  out  NUM_CH  registered channel outputs.
- period_tick  out  1  one-cycle pulse on each period wrap.

## Operation
- Window: BASE_ADDR .. BASE_ADDR+0x0F+4*NUM_CH. Offsets:
  - 0x00 CTRL: bit0 EN, bit1 INV (invert all outputs).
  - 0x04 PERIOD: CNT_W bits.
  - 0x08 PRESCALE: PRE_W bits.
  - 0x0C COUNT: read-only.
  - 0x10+4*i DUTY[i].
- Unused write bits are dropped; unused read bits return 0. Writes to COUNT or to undefined in-window offsets are ignored.
- Reset values:
  - CTRL=0, PERIOD=2^CNT_W−1, PRESCALE=0, DUTY[i]=0.
  - prescaler=0, counter=0.
  - pwm_out=0, period_tick=0, read_data=0, read_hit=0.
- Prescaler counts 0..PRESCALE and asserts an internal tick when prescaler≥PRESCALE, then returns to 0. With PRESCALE=0, tick fires every cycle.
- Counter advances only on tick:
  - If counter≥PERIOD: counter←0 and a wrap event occurs; period_tick=1 in the following cycle.
  - Otherwise: counter+1.
  - Writing a smaller PERIOD than the current count forces a wrap on the next tick. No out-of-range states exist.
- Channel compare: raw[i] = EN & (counter < duty_act[i]).
  - duty_act=0 gives constant low.
  - duty_act>PERIOD gives constant high.
  - Duty cycle is duty/(PERIOD+1).
  - pwm_out[i] ← raw[i] XOR INV.
- EN=0 (disabled):
  - Prescaler and counter are held at 0; no ticks or wraps occur.
  - pwm_out = {NUM_CH{INV}}.
  - Registers remain writable.
- A 0→1 transition of EN starts counting from 0.
- Simultaneous wrap and DUTY write: the written value goes to DUTY; duty_act takes the old DUTY (see Configuration).
- Reset asserted mid-period: all state returns to its reset values immediately; no pulse completes.

## Timing
- Write: the register updates on the clk edge where write_mem=1 and the address hits. It affects raw compare in that next cycle, and pwm_out one cycle later (2-edge write-to-output).
- Read: read_data and read_hit are valid one cycle after read_address is presented. Out-of-window reads return read_data=0, read_hit=0.
- pwm_out lags counter by exactly 1 cycle.
- period_tick is high for exactly 1 clk per wrap, including when PRESCALE=0 and PERIOD=0 (high every cycle).
- Read and write may target different offsets in the same cycle. A same-offset read returns the pre-write value.

## Configuration
- PWM_IO_BANK_SHADOW_EN defined:
  - duty_act[i] is a shadow register loaded from DUTY[i] only on a wrap event, or every cycle while EN=0.
  - Glitch-free mid-period duty updates.
- Not defined:
  - duty_act[i] is DUTY[i] directly; writes take effect on the next compare.
  - No shadow flops are built.

## Test plan
- Reset: assert reset mid-run with EN=1, DUTY[0]=0x40 → all outputs 0 and COUNT reads 0 on the next read; PERIOD reads 0xFF.
- Basic duty: PERIOD=9, PRESCALE=0, DUTY[0]=3, EN=1 → pwm_out[0] high 3 cycles / low 7 cycles repeating; period_tick every 10 cycles.
- Extremes: DUTY[1]=0 and DUTY[2]=10 with PERIOD=9 → ch1 constant 0 and ch2 constant 1; INV=1 → both inverted.
- Prescale: PRESCALE=2, PERIOD=3 → COUNT steps every 3 clks; period_tick period is 12 clks.
- Shadow (macro on): change DUTY[0] 3→7 mid-period at counter=5 → current period keeps 3 high cycles; the next period has 7. With the macro off, the change applies at the next compare.
- Bus: read of BASE_ADDR+0x10 → DUTY[0] with read_hit=1 one cycle later; read of BASE_ADDR+0x100 → read_data=0, read_hit=0; write of BASE_ADDR+0x0C leaves COUNT unchanged.
